// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define DIV_FAST_PATH_EN to finish divide-by-zero and signed overflow in one cycle.
module div_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  input  logic [1:0]  i_div_op,
  output logic        o_busy,
  output logic        o_valid,
  output logic [31:0] o_div_data
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        sel_rem_q, sel_rem_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d;
  logic        dz_q, dz_d, ovf_q, ovf_d;
  logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, data_q, data_d;
  logic [5:0]  cnt_q, cnt_d;

  logic        in_signed, a_neg, b_neg, in_dz, in_ovf;
  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] rem_nxt, quo_nxt, q_fin, r_fin, final_res;

  always_comb begin
    in_signed = ~i_div_op[0];
    a_neg     = in_signed & i_op_a[31];
    b_neg     = in_signed & i_op_b[31];
    a_mag     = a_neg ? -i_op_a : i_op_a;
    b_mag     = b_neg ? -i_op_b : i_op_b;
    in_dz     = (i_op_b == 32'h0);
    in_ovf    = in_signed && (i_op_a == 32'h8000_0000) && (i_op_b == 32'hFFFF_FFFF);
  end

  // The remainder is always below the divisor, so once the 33-bit trial
  // succeeds the difference fits in 32 bits and a 32-bit subtract is exact.
  always_comb begin
    rem_sh  = {rem_q, quo_q[31]};
    ge      = (rem_sh >= {1'b0, dvs_q});
    rem_nxt = ge ? (rem_sh[31:0] - dvs_q) : rem_sh[31:0];
    quo_nxt = {quo_q[30:0], ge};
  end

  // With a zero divisor the loop leaves |a| in the remainder, so the signed
  // correction already restores the original dividend for REM/REMU.
  always_comb begin
    q_fin = qneg_q ? -quo_nxt : quo_nxt;
    r_fin = rneg_q ? -rem_nxt : rem_nxt;
    if (dz_q) q_fin = 32'hFFFF_FFFF;
    if (ovf_q) begin
      q_fin = 32'h8000_0000;
      r_fin = 32'h0;
    end
    final_res = sel_rem_q ? r_fin : q_fin;
  end

`ifdef DIV_FAST_PATH_EN
  logic [31:0] fast_res;
  always_comb begin
    if (in_dz) fast_res = i_div_op[1] ? i_op_a : 32'hFFFF_FFFF;
    else       fast_res = i_div_op[1] ? 32'h0 : 32'h8000_0000;
  end
`endif

  always_comb begin
    state_d   = state_q;
    sel_rem_d = sel_rem_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          sel_rem_d = i_div_op[1];
          qneg_d    = a_neg ^ b_neg;
          rneg_d    = a_neg;
          dz_d      = in_dz;
          ovf_d     = in_ovf;
          quo_d     = a_mag;
          dvs_d     = b_mag;
          rem_d     = 32'h0;
          cnt_d     = 6'd0;
          state_d   = S_CALC;
`ifdef DIV_FAST_PATH_EN
          if (in_dz || in_ovf) begin
            state_d = S_DONE;
            data_d  = fast_res;
          end
`endif
        end
      end
      S_CALC: begin
        quo_d = quo_nxt;
        rem_d = rem_nxt;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_DONE;
          data_d  = final_res;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      sel_rem_q <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      quo_q     <= 32'h0;
      rem_q     <= 32'h0;
      dvs_q     <= 32'h0;
      cnt_q     <= 6'd0;
      data_q    <= 32'h0;
    end else begin
      state_q   <= state_d;
      sel_rem_q <= sel_rem_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
    end
  end

  assign o_busy     = (state_q != S_IDLE);
  assign o_valid    = (state_q == S_DONE);
  assign o_div_data = data_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: accepts are predicted by a timing model,
// results come from plain SV arithmetic following the RISC-V M rules.
module tb_div_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [31:0] i_op_a, i_op_b;
  logic [1:0]  i_div_op;
  logic        o_busy, o_valid;
  logic [31:0] o_div_data;

  div_unit dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_op_a(i_op_a), .i_op_b(i_op_b), .i_div_op(i_div_op),
    .o_busy(o_busy), .o_valid(o_valid), .o_div_data(o_div_data)
  );

  always #5 i_clk = ~i_clk;

`ifdef DIV_FAST_PATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    int          t0;
    int          lat;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   free_at = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   vcount  = 0;
  logic exp_v;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    logic signed [31:0] sa, sbv, sq, sr;
    logic               ovf;
    logic [31:0]        r;
    sa  = a;
    sbv = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = 32'h0;
    if (b == 32'h0) begin
      r = op[1] ? a : 32'hFFFF_FFFF;
    end else if (!op[0] && ovf) begin
      r = op[1] ? 32'h0 : 32'h8000_0000;
    end else begin
      sq = sa / sbv;
      sr = sa % sbv;
      case (op)
        2'b00:   r = sq;
        2'b01:   r = a / b;
        2'b10:   r = sr;
        default: r = a % b;
      endcase
    end
    return r;
  endfunction

  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b,
                                    input logic [1:0] op);
    return (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Accept model: a start is taken only when the model says the unit is idle.
  always @(posedge i_clk) begin
    if (i_rst) begin
      free_at = 0;
    end else if (i_start && cyc >= free_at) begin
      exp_t e;
      e.t0   = cyc;
      e.lat  = (FAST && is_special(i_op_a, i_op_b, i_div_op)) ? 1 : 33;
      e.data = ref_res(i_op_a, i_op_b, i_div_op);
      sb.push_back(e);
      free_at = cyc + e.lat + 1;
    end
  end

  always @(negedge i_clk) begin
    if (i_rst) begin
      sb.delete();
      chk("rst_busy", {31'h0, o_busy}, 32'h0);
      chk("rst_valid", {31'h0, o_valid}, 32'h0);
      chk("rst_data", o_div_data, 32'h0);
    end else begin
      chk("busy", {31'h0, o_busy}, {31'h0, (cyc < free_at)});
      exp_v = (sb.size() > 0) && (cyc == sb[0].t0 + sb[0].lat);
      chk("valid", {31'h0, o_valid}, {31'h0, exp_v});
      if (o_valid) vcount++;
      if (exp_v) begin
        chk("data", o_div_data, sb[0].data);
        void'(sb.pop_front());
      end else if (sb.size() > 0 && cyc > sb[0].t0 + sb[0].lat) begin
        void'(sb.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge i_clk);
    while (cyc < free_at && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 32'h1, 32'h0);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    wait_idle();
    i_op_a   = a;
    i_op_b   = b;
    i_div_op = op;
    i_start  = 1'b1;
    @(posedge i_clk);
    #1;
    i_start  = 1'b0;
    i_op_a   = $urandom;
    i_op_b   = $urandom;
    i_div_op = 2'($urandom_range(0, 3));
  endtask

  task automatic do_reset(input int ncyc);
    i_rst = 1'b1;
    repeat (ncyc) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  initial begin
    int base;
    logic [31:0] ra, rb;
    i_rst    = 1'b1;
    i_start  = 1'b0;
    i_op_a   = 32'h0;
    i_op_b   = 32'h0;
    i_div_op = 2'b00;
    #1;
    chk("init_busy", {31'h0, o_busy}, 32'h0);
    chk("init_valid", {31'h0, o_valid}, 32'h0);
    chk("init_data", o_div_data, 32'h0);
    do_reset(3);

    issue(32'd100, 32'd7, 2'b00);
    issue(32'd100, 32'd7, 2'b10);
    issue(32'hFFFF_FF9C, 32'd7, 2'b00);
    issue(32'hFFFF_FF9C, 32'd7, 2'b10);
    issue(32'hFFFF_FFFF, 32'd2, 2'b01);
    issue(32'h1234_5678, 32'h0, 2'b00);
    issue(32'h1234_5678, 32'h0, 2'b11);
    issue(32'h1234_5678, 32'h0, 2'b01);
    issue(32'hF234_5678, 32'h0, 2'b10);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 2'b00);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 2'b10);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 2'b01);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'h0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2, 3:    rb = 32'($urandom_range(1, 300));
        4:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: rb = $urandom;
      endcase
      issue(ra, rb, 2'($urandom_range(0, 3)));
    end

    // operand changes and stray starts while the loop is running
    issue(32'd1000, 32'd33, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      i_op_a  = $urandom;
      i_op_b  = $urandom;
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
    end

    // reset after the tenth iteration
    issue(32'd123456, 32'd789, 2'b01);
    repeat (10) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    #1;
    chk("midrst_busy", {31'h0, o_busy}, 32'h0);
    chk("midrst_valid", {31'h0, o_valid}, 32'h0);
    chk("midrst_data", o_div_data, 32'h0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    issue(32'd5000, 32'd9, 2'b11);

    // start held high: one accept per busy period
    wait_idle();
    base     = vcount;
    i_op_a   = 32'd100;
    i_op_b   = 32'd7;
    i_div_op = 2'b00;
    i_start  = 1'b1;
    repeat (102) @(negedge i_clk);
    i_start  = 1'b0;
    wait_idle();
    repeat (2) @(negedge i_clk);
    chk("b2b_valid_count", 32'(vcount - base), 32'd3);

    begin
      int n = 0;
      while (sb.size() > 0 && n < 200) begin
        @(negedge i_clk);
        n++;
      end
      if (n >= 200) chk("drain_timeout", 32'h1, 32'h0);
    end
    @(negedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
